knap_enum_ctrl: RTL and testbench
=================================

Name: knap_enum_ctrl

Overview:
- Exhaustive-search sequencer for the multi-constraint knapsack checker (value/weight/volume feasibility block).
- Enumerates every item-selection vector, drives it onto the checker's item inputs and samples the checker's `valid` output.
- Reports the number of feasible selections and the first feasible selection found.
- Supports a checker with optional pipeline latency, early stop on the first solution, and abort.

Parameters:
- NUM_ITEMS, 18: number of item select bits; cand[0] is item A, cand[1] is item B, and so on.
- CHK_LAT, 0: checker latency in cycles, legal range 0..4. 0 means the checker is combinational and `valid` belongs to `cand` in the same cycle.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a search. Accepted only in IDLE or DONE.
- stop_first  in  1  search mode; sampled on an accepted start. 1 means stop at the first feasible result.
- abort  in  1  cancels a search in progress.
- cand  out  NUM_ITEMS  selection vector driven to the checker item inputs.
- chk_valid  in  1  checker result for the candidate issued CHK_LAT cycles earlier.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  level; high in DONE, held until the next accepted start.
- found  out  1  at least one feasible selection recorded.
- first_sol  out  NUM_ITEMS  first feasible selection, in enumeration order.
- sol_count  out  NUM_ITEMS+1  number of feasible selections; holds 2^NUM_ITEMS without overflow.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-search):
  - state=IDLE.
  - cand, first_sol and sol_count = 0.
  - busy, done and found = 0.
  - Pipeline tag bits cleared.
- States: IDLE, RUN, DRAIN, DONE.
- Accepted start (in IDLE or DONE):
  - Clears sol_count, found, first_sol and all tags; drops done.
  - Latches stop_first; sets cand=0.
  - Next state is RUN.
  - start is ignored in RUN and DRAIN.
- RUN:
  - One candidate issued per cycle, in order cand = 0, 1, ..., 2^NUM_ITEMS-1.
  - A tag shift register of depth CHK_LAT carries (issue-valid, candidate) pairs so each chk_valid sample is matched to its candidate.
  - With CHK_LAT=0 the current cand is the match.
- Result sample, in the cycle a tagged result arrives with chk_valid=1:
  - sol_count increments.
  - If found=0: first_sol = matched candidate and found becomes 1.
  - chk_valid is ignored when there is no valid tag.
- End of enumeration:
  - When all-ones is issued, the next state is DRAIN if CHK_LAT>0, otherwise DONE.
  - cand holds at all-ones and does not wrap.
- DRAIN:
  - Lasts exactly CHK_LAT cycles; results keep being sampled.
  - Next state is DONE.
- stop_first=1:
  - The first feasible result goes straight to DONE in the same edge, after that result is recorded.
  - In-flight results behind it are discarded; sol_count=1.
  - If no selection is feasible, full enumeration runs and ends with found=0.
- DONE: done=1, busy=0, cand holds its last value, all outputs are stable.
- abort in RUN or DRAIN:
  - Next state is IDLE; busy=0, done=0, tags cleared.
  - sol_count, found and first_sol freeze at their values (partial results stay readable).
  - abort in IDLE or DONE has no effect.
- start and abort in the same cycle: abort wins when busy; start wins in IDLE or DONE.
- Total cycles from start to done=1: 2^NUM_ITEMS + CHK_LAT + 1, when stop_first=0 and abort is not asserted.

Test Plan:
1. NUM_ITEMS=4, CHK_LAT=0, stub checker valid when popcount(cand)>=3, stop_first=0, one start pulse.
   - done rises 17 cycles after start; sol_count=5, found=1, first_sol=4'b0111.
2. Same setup, CHK_LAT=2 (stub registers its result twice).
   - done rises 19 cycles after start; sol_count=5, first_sol=4'b0111.
   - No off-by-one in the candidate/result pairing.
3. stop_first=1, CHK_LAT=2, stub valid only for cand==4'b0101.
   - done=1, sol_count=1, first_sol=4'b0101.
   - Results for 0110 and 0111 in flight are discarded.
4. Stub never valid, NUM_ITEMS=4.
   - done=1, found=0, sol_count=0, first_sol=0, cand=4'b1111.
5. Assert abort at cand==4'b1000 with the popcount stub, then start again.
   - After abort: busy=0, done=0, sol_count=0 (no valid results yet). A start pulse applied while in RUN is ignored.
   - Restart completes with sol_count=5.
6. Assert rst asynchronously mid-RUN, between clock edges.
   - All outputs go to 0 immediately.
   - A start after rst deasserts gives the same results as scenario 1.

Source files
------------

// File: rtl/knap_enum_ctrl_if.sv
// Handshake and result bundle between the knapsack search sequencer, its host and the
// feasibility checker. The sequencer side uses the slave modport, the host the master.
interface knap_enum_ctrl_if #(
  parameter int NUM_ITEMS = 18
);
  logic                 start;
  logic                 stop_first;
  logic                 abort;
  logic                 chk_valid;
  logic [NUM_ITEMS-1:0] cand;
  logic                 busy;
  logic                 done;
  logic                 found;
  logic [NUM_ITEMS-1:0] first_sol;
  logic [NUM_ITEMS:0]   sol_count;

  modport master (
    output start, stop_first, abort, chk_valid,
    input  cand, busy, done, found, first_sol, sol_count
  );

  modport slave (
    input  start, stop_first, abort, chk_valid,
    output cand, busy, done, found, first_sol, sol_count
  );
endinterface

// File: rtl/knap_enum_ctrl.sv
// Exhaustive-search sequencer for the multi-constraint knapsack checker. Walks every
// selection vector in binary order, pairs each checker verdict with the candidate it
// belongs to through a tag pipeline matching the checker latency, and records the
// number of feasible selections plus the first one seen.
module knap_enum_ctrl #(
  parameter int NUM_ITEMS = 18,
  parameter int CHK_LAT   = 0
) (
  input logic              clk,
  input logic              rst,
  knap_enum_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A combinational checker still needs one tag slot so the arrays stay legal.
  localparam int TAG_DEPTH = (CHK_LAT > 0) ? CHK_LAT : 1;
  localparam logic [NUM_ITEMS-1:0] ALL_ONES = '1;

  state_t               r_state;
  logic [NUM_ITEMS-1:0] r_cand;
  logic [NUM_ITEMS-1:0] r_firstSol;
  logic [NUM_ITEMS:0]   r_solCount;
  logic                 r_found;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_stopFirst;
  logic [2:0]           r_drainCnt;
  logic [TAG_DEPTH-1:0] r_tagValid;
  logic [NUM_ITEMS-1:0] r_tagCand [TAG_DEPTH];

  logic                 w_active;
  logic                 w_matchValid;
  logic [NUM_ITEMS-1:0] w_matchCand;
  logic                 w_hit;
  logic                 w_lastCand;
  logic                 w_drainEnd;

  // With no checker latency the verdict belongs to the candidate on the wires right now;
  // otherwise it belongs to the oldest tag in the pipeline.
  assign w_active     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_matchValid = (CHK_LAT == 0) ? (r_state == ST_RUN) : r_tagValid[TAG_DEPTH-1];
  assign w_matchCand  = (CHK_LAT == 0) ? r_cand : r_tagCand[TAG_DEPTH-1];
  assign w_hit        = w_active && w_matchValid && bus.chk_valid;
  assign w_lastCand   = (r_cand == ALL_ONES);
  assign w_drainEnd   = (r_drainCnt == 3'(CHK_LAT - 1));

  // Search state machine: candidate issue, verdict pairing, result capture and mode control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cand      <= '0;
      r_firstSol  <= '0;
      r_solCount  <= '0;
      r_found     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stopFirst <= 1'b0;
      r_drainCnt  <= '0;
      r_tagValid  <= '0;
      for (int k = 0; k < TAG_DEPTH; k++) r_tagCand[k] <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state     <= ST_RUN;
            r_stopFirst <= bus.stop_first;
            r_cand      <= '0;
            r_firstSol  <= '0;
            r_solCount  <= '0;
            r_found     <= 1'b0;
            r_tagValid  <= '0;
            r_drainCnt  <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        default: begin
          if (bus.abort) begin
            // Partial results stay readable; only the sequencing is cancelled.
            r_state    <= ST_IDLE;
            r_tagValid <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
          end else begin
            if (w_hit) begin
              r_solCount <= r_solCount + 1'b1;
              if (!r_found) begin
                r_found    <= 1'b1;
                r_firstSol <= w_matchCand;
              end
            end
            if (w_hit && r_stopFirst) begin
              // Verdicts still in flight behind the first solution are thrown away.
              r_state    <= ST_DONE;
              r_tagValid <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              for (int k = TAG_DEPTH - 1; k > 0; k--) begin
                r_tagValid[k] <= r_tagValid[k-1];
                r_tagCand[k]  <= r_tagCand[k-1];
              end
              r_tagValid[0] <= (r_state == ST_RUN);
              r_tagCand[0]  <= r_cand;
              if (r_state == ST_RUN) begin
                if (w_lastCand) begin
                  if (CHK_LAT > 0) begin
                    r_state    <= ST_DRAIN;
                    r_drainCnt <= '0;
                  end else begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                  end
                end else begin
                  r_cand <= r_cand + 1'b1;
                end
              end else begin
                if (w_drainEnd) begin
                  r_state    <= ST_DONE;
                  r_tagValid <= '0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                end else begin
                  r_drainCnt <= r_drainCnt + 3'd1;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.cand      = r_cand;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.found     = r_found;
  assign bus.first_sol = r_firstSol;
  assign bus.sol_count = r_solCount;

endmodule

// File: tb/tb_knap_enum_ctrl.sv
// Bench for knap_enum_ctrl: a combinational-checker instance and a two-cycle-latency
// instance, each driven by a stub checker. Expected results are queued when a search is
// launched and compared by a monitor when the instance drops busy.
module tb_knap_enum_ctrl;

  typedef struct {
    string      name;
    logic       expDone;
    logic       expFound;
    logic [4:0] expSol;
    logic [3:0] expFirst;
    logic [3:0] expCand;
    bit         candCare;
    int         expLat;
  } expect_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;
  int   cycleCnt;
  int   startMark [2];
  int   mode0;
  int   mode1;
  bit   prevBusy0;
  bit   prevBusy1;
  logic stubStage1;
  logic stubStage2;
  expect_t q0 [$];
  expect_t q1 [$];

  knap_enum_ctrl_if #(.NUM_ITEMS(4)) bus0 ();
  knap_enum_ctrl_if #(.NUM_ITEMS(4)) bus1 ();

  knap_enum_ctrl #(.NUM_ITEMS(4), .CHK_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  knap_enum_ctrl #(.NUM_ITEMS(4), .CHK_LAT(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Stub checker: 0 = at least three items chosen, 1 = only 0101 feasible, else never.
  function automatic logic stubFn(input int mode, input logic [3:0] c);
    case (mode)
      0:       return ($countones(c) >= 3);
      1:       return (c == 4'b0101);
      default: return 1'b0;
    endcase
  endfunction

  assign bus0.chk_valid = stubFn(mode0, bus0.cand);
  assign bus1.chk_valid = stubStage2;

  // Two-register checker model for the latency-2 instance.
  always @(posedge clk) begin
    stubStage1 <= stubFn(mode1, bus1.cand);
    stubStage2 <= stubStage1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running edge count used to measure start-to-done latency.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic busyOf(input int d);
    return (d == 0) ? bus0.busy : bus1.busy;
  endfunction

  // Scoreboard compare: pops the oldest expectation of instance d.
  task automatic checkOutput(input int d, input logic aDone, input logic aFound,
                             input logic [4:0] aSol, input logic [3:0] aFirst,
                             input logic [3:0] aCand);
    expect_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL unexpected_end dut%0d: busy fell with nothing queued", d);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    checkField({e.name, " done"}, 32'(aDone), 32'(e.expDone));
    checkField({e.name, " found"}, 32'(aFound), 32'(e.expFound));
    checkField({e.name, " sol_count"}, 32'(aSol), 32'(e.expSol));
    checkField({e.name, " first_sol"}, 32'(aFirst), 32'(e.expFirst));
    if (e.candCare) checkField({e.name, " cand"}, 32'(aCand), 32'(e.expCand));
    if (e.expLat >= 0) checkField({e.name, " latency"}, 32'(cycleCnt - startMark[d]), 32'(e.expLat));
  endtask

  // Monitor: whenever an instance leaves RUN/DRAIN outside reset, score its outputs.
  always @(negedge clk) begin
    if (rst) begin
      prevBusy0 = 1'b0;
      prevBusy1 = 1'b0;
    end else begin
      if (prevBusy0 && !bus0.busy)
        checkOutput(0, bus0.done, bus0.found, bus0.sol_count, bus0.first_sol, bus0.cand);
      if (prevBusy1 && !bus1.busy)
        checkOutput(1, bus1.done, bus1.found, bus1.sol_count, bus1.first_sol, bus1.cand);
      prevBusy0 = bus0.busy;
      prevBusy1 = bus1.busy;
    end
  end

  function automatic expect_t mkExp(input string name, input logic dn, input logic fd,
                                    input logic [4:0] sol, input logic [3:0] first,
                                    input logic [3:0] cand, input bit candCare, input int lat);
    expect_t e;
    e.name = name; e.expDone = dn; e.expFound = fd; e.expSol = sol;
    e.expFirst = first; e.expCand = cand; e.candCare = candCare; e.expLat = lat;
    return e;
  endfunction

  // Launches a search on instance d; queues its expectation when push is set.
  task automatic applyStimulus(input int d, input logic stopFirst, input int mode,
                               input bit push, input expect_t e);
    @(negedge clk);
    if (d == 0) begin
      mode0 = mode; bus0.stop_first = stopFirst; bus0.start = 1'b1;
      if (push) q0.push_back(e);
    end else begin
      mode1 = mode; bus1.stop_first = stopFirst; bus1.start = 1'b1;
      if (push) q1.push_back(e);
    end
    startMark[d] = cycleCnt;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic waitIdle(input int d, input int maxCyc);
    int n = 0;
    while (busyOf(d) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    if (busyOf(d)) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL timeout dut%0d: still busy after %0d cycles", d, maxCyc);
    end
    @(negedge clk);
  endtask

  task automatic waitCand(input int d, input logic [3:0] value, input int maxCyc);
    int n = 0;
    while (((d == 0) ? bus0.cand : bus1.cand) != value && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    if (((d == 0) ? bus0.cand : bus1.cand) != value) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL timeout dut%0d: cand never reached %0h", d, value);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expect_t none;
    testsRun = 0; testsFailed = 0; cycleCnt = 0;
    mode0 = 2; mode1 = 2;
    none = mkExp("none", 1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 1'b0, -1);
    bus0.start = 1'b0; bus0.stop_first = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.stop_first = 1'b0; bus1.abort = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    checkField("reset dut0 cand", 32'(bus0.cand), 32'd0);
    checkField("reset dut0 busy", 32'(bus0.busy), 32'd0);
    checkField("reset dut0 done", 32'(bus0.done), 32'd0);
    checkField("reset dut0 found", 32'(bus0.found), 32'd0);
    checkField("reset dut0 sol_count", 32'(bus0.sol_count), 32'd0);
    checkField("reset dut1 cand", 32'(bus1.cand), 32'd0);
    checkField("reset dut1 busy", 32'(bus1.busy), 32'd0);
    checkField("reset dut1 first_sol", 32'(bus1.first_sol), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full enumeration, popcount>=3 feasible: 0111,1011,1101,1110,1111.
    applyStimulus(0, 1'b0, 0, 1'b1, mkExp("s1_comb", 1'b1, 1'b1, 5'd5, 4'b0111, 4'b1111, 1'b1, 17));
    waitIdle(0, 40);
    repeat (3) @(negedge clk);
    checkField("s1 done held", 32'(bus0.done), 32'd1);
    checkField("s1 sol_count held", 32'(bus0.sol_count), 32'd5);

    // Nothing feasible.
    applyStimulus(0, 1'b0, 2, 1'b1, mkExp("s4_never", 1'b1, 1'b0, 5'd0, 4'd0, 4'b1111, 1'b1, 17));
    waitIdle(0, 40);

    // Same popcount checker behind two registers.
    applyStimulus(1, 1'b0, 0, 1'b1, mkExp("s2_lat2", 1'b1, 1'b1, 5'd5, 4'b0111, 4'b1111, 1'b1, 19));
    waitIdle(1, 40);

    // Stop at first solution; 0110/0111 verdicts in flight are discarded.
    applyStimulus(1, 1'b1, 1, 1'b1, mkExp("s3_stop", 1'b1, 1'b1, 5'd1, 4'b0101, 4'b0111, 1'b1, 9));
    waitIdle(1, 40);

    // Abort at cand 1000 after an ignored start pulse mid-run, then restart.
    applyStimulus(1, 1'b0, 0, 1'b1, mkExp("s5_abort", 1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 1'b0, -1));
    waitCand(1, 4'd3, 20);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    checkField("s5 start ignored cand", 32'(bus1.cand), 32'd4);
    checkField("s5 start ignored busy", 32'(bus1.busy), 32'd1);
    waitCand(1, 4'd8, 20);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    @(negedge clk);
    checkField("s5 idle after abort", 32'(bus1.busy), 32'd0);
    applyStimulus(1, 1'b0, 0, 1'b1, mkExp("s5_restart", 1'b1, 1'b1, 5'd5, 4'b0111, 4'b1111, 1'b1, 19));
    waitIdle(1, 40);

    // Asynchronous reset between clock edges, then a clean rerun.
    applyStimulus(0, 1'b0, 0, 1'b0, none);
    waitCand(0, 4'd12, 20);
    checkField("s6 partial sol_count", 32'(bus0.sol_count), 32'd2);
    #3 rst = 1'b1;
    #1;
    checkField("s6 async cand", 32'(bus0.cand), 32'd0);
    checkField("s6 async busy", 32'(bus0.busy), 32'd0);
    checkField("s6 async done", 32'(bus0.done), 32'd0);
    checkField("s6 async found", 32'(bus0.found), 32'd0);
    checkField("s6 async first_sol", 32'(bus0.first_sol), 32'd0);
    checkField("s6 async sol_count", 32'(bus0.sol_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b0, 0, 1'b1, mkExp("s6_rerun", 1'b1, 1'b1, 5'd5, 4'b0111, 4'b1111, 1'b1, 17));
    waitIdle(0, 40);

    checkField("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
